osc_trigger_capture: RTL and testbench

Triggered sample-capture stage between bfsk_modulator and oscilloscope.
- Decimates the 16-bit modulated sample stream.
- Keeps a circular pre-trigger history and detects a rising-level trigger, with auto-trigger fallback.
- Freezes one screen-width record, which the oscilloscope reads by column address.
- Re-arms on the display frame boundary, so the waveform is stable on screen instead of free-running.

---
 rtl/osc_trigger_capture_pkg.sv | 17 +
 rtl/osc_trigger_capture_sample_ram.sv | 27 ++
 rtl/osc_trigger_capture.sv | 151 +++++++++++++++
 tb/tb_osc_trigger_capture.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/osc_trigger_capture_pkg.sv
// Shared definitions for the oscilloscope trigger/capture stage: capture FSM
// states and default record geometry reused by the scope column counter.
package osc_trigger_capture_pkg;

  localparam int unsigned OSC_DEPTH  = 640;
  localparam int unsigned OSC_ADDR_W = 10;
  localparam int unsigned OSC_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } cap_state_t;

endpackage

// File: rtl/osc_trigger_capture_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port,
// single clock, written so it maps onto M10K block RAM.
module osc_sample_ram
  import osc_trigger_capture_pkg::*;
#(
  parameter int unsigned DEPTH  = OSC_DEPTH,
  parameter int unsigned ADDR_W = OSC_ADDR_W,
  parameter int unsigned DATA_W = OSC_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/osc_trigger_capture.sv
// Triggered capture stage between bfsk_modulator and the oscilloscope:
// decimate, keep pre-trigger history, freeze one record, re-arm on frame sync.
module osc_trigger_capture
  import osc_trigger_capture_pkg::*;
#(
  parameter int unsigned DEPTH    = OSC_DEPTH,
  parameter int unsigned ADDR_W   = OSC_ADDR_W,
  parameter int unsigned PRE_TRIG = 64,
  parameter int unsigned DECIM    = 4,
  parameter int unsigned AUTO_TMO = 4096
) (
  input  logic              CLOCK_50,
  input  logic              RESET_n,
  input  logic              sample_en,
  input  logic [15:0]       signal,
  input  logic [15:0]       trig_level,
  input  logic              hold,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  output logic              capture_valid,
  output logic              triggered,
  output logic              busy
);

  localparam int unsigned DECIM_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned TMO_W   = $clog2(AUTO_TMO + 1);

  cap_state_t         state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr, start_ptr, fill_cnt, post_cnt, rd_phys;
  logic [DECIM_W-1:0] decim_cnt;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [15:0]        prev_sample, ram_q;
  logic [ADDR_W:0]    rd_sum;
  logic               capturing, store, crossing, trig_store, auto_store;
  logic               rd_in_range, rd_zero_q;

  always_comb begin
    capturing  = (state_q == ST_PREFILL) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
    store      = capturing && sample_en && (decim_cnt == '0);
    crossing   = (prev_sample < trig_level) && (signal >= trig_level);
    trig_store = store && (state_q == ST_WAIT_TRIG) && crossing;
    auto_store = store && (state_q == ST_WAIT_TRIG) && !crossing
                 && (tmo_cnt == TMO_W'(AUTO_TMO - 1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (!hold) state_d = ST_PREFILL;
      ST_PREFILL:   if (store && (fill_cnt == ADDR_W'(PRE_TRIG - 1))) state_d = ST_WAIT_TRIG;
      ST_WAIT_TRIG: if (trig_store || auto_store) state_d = ST_POST;
      ST_POST:      if (store && (post_cnt == ADDR_W'(DEPTH - PRE_TRIG - 2))) state_d = ST_DONE;
      ST_DONE:      if (frame_start && !hold) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    busy          = capturing;
    capture_valid = (state_q == ST_DONE);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= ST_IDLE;
      wr_ptr      <= '0;
      decim_cnt   <= '0;
      fill_cnt    <= '0;
      post_cnt    <= '0;
      tmo_cnt     <= '0;
      start_ptr   <= '0;
      prev_sample <= '0;
      triggered   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == ST_IDLE) begin
        decim_cnt <= '0;
        fill_cnt  <= '0;
        tmo_cnt   <= '0;
      end else begin
        if (capturing && sample_en) begin
          decim_cnt <= (decim_cnt == DECIM_W'(DECIM - 1)) ? '0 : decim_cnt + DECIM_W'(1);
        end
        if (store && (state_q == ST_PREFILL)) begin
          fill_cnt <= fill_cnt + ADDR_W'(1);
        end
        if (store && (state_q == ST_WAIT_TRIG) && !crossing) begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end

      if (store) begin
        wr_ptr      <= (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + ADDR_W'(1);
        prev_sample <= signal;
      end

      // The trigger sample itself is record index PRE_TRIG, so the record
      // starts PRE_TRIG slots behind the address it is written to.
      if (trig_store || auto_store) begin
        if (wr_ptr >= ADDR_W'(PRE_TRIG)) begin
          start_ptr <= wr_ptr - ADDR_W'(PRE_TRIG);
        end else begin
          start_ptr <= wr_ptr + ADDR_W'(DEPTH - PRE_TRIG);
        end
        post_cnt  <= '0;
        triggered <= trig_store;
      end else if (store && (state_q == ST_POST)) begin
        post_cnt <= post_cnt + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    rd_in_range = ({1'b0, rd_addr} < (ADDR_W + 1)'(DEPTH));
    rd_sum      = {1'b0, start_ptr} + {1'b0, rd_addr};
    if (!rd_in_range) begin
      rd_phys = '0;
    end else if (rd_sum >= (ADDR_W + 1)'(DEPTH)) begin
      rd_phys = ADDR_W'(rd_sum - (ADDR_W + 1)'(DEPTH));
    end else begin
      rd_phys = rd_sum[ADDR_W-1:0];
    end
  end

  // RAM output register has no reset; a resettable zero flag forces rd_data
  // to 0 out of reset and for out-of-range columns.
  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      rd_zero_q <= 1'b1;
    end else begin
      rd_zero_q <= !rd_in_range;
    end
  end

  always_comb begin
    rd_data = rd_zero_q ? '0 : ram_q;
  end

  osc_sample_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (16)
  ) u_ram (
    .clk   (CLOCK_50),
    .we    (store),
    .waddr (wr_ptr),
    .wdata (signal),
    .raddr (rd_phys),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_osc_trigger_capture.sv
// Bench for osc_trigger_capture: two instances (DECIM=1 and DECIM=4) share
// stimulus; record reads are checked through an expected-value queue.
module tb_osc_trigger_capture;

  logic        clk = 1'b0;
  logic        rst_n, sample_en, hold, frame_start;
  logic [15:0] sig, trig_level;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data, rd_data4;
  logic        cv, trg, busy, cv4, trg4, busy4;

  always #5 clk = ~clk;

  osc_trigger_capture #(
    .DEPTH(640), .ADDR_W(10), .PRE_TRIG(64), .DECIM(1), .AUTO_TMO(4096)
  ) dut (
    .CLOCK_50(clk), .RESET_n(rst_n), .sample_en(sample_en), .signal(sig),
    .trig_level(trig_level), .hold(hold), .frame_start(frame_start),
    .rd_addr(rd_addr), .rd_data(rd_data), .capture_valid(cv),
    .triggered(trg), .busy(busy)
  );

  osc_trigger_capture #(
    .DEPTH(640), .ADDR_W(10), .PRE_TRIG(64), .DECIM(4), .AUTO_TMO(4096)
  ) dut4 (
    .CLOCK_50(clk), .RESET_n(rst_n), .sample_en(sample_en), .signal(sig),
    .trig_level(trig_level), .hold(hold), .frame_start(frame_start),
    .rd_addr(rd_addr), .rd_data(rd_data4), .capture_valid(cv4),
    .triggered(trg4), .busy(busy4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endfunction

  typedef struct {
    string       name;
    bit          sel;
    logic [15:0] exp;
  } rd_exp_t;

  rd_exp_t sb[$];
  logic    rd_req  = 1'b0;
  logic    rd_pend = 1'b0;

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin : monitor
    rd_exp_t e;
    if (rd_pend) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got read response, expected none queued");
      end else begin
        e = sb.pop_front();
        check(e.name, e.sel ? rd_data4 : rd_data, e.exp);
      end
    end
  end

  // Issue one column read; caller is sitting on a negedge.
  task automatic rd(input string name, input bit sel, input logic [9:0] addr,
                    input logic [15:0] exp);
    rd_exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    rd_addr = addr;
    rd_req  = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; hold = 1'b1; sample_en = 1'b0; frame_start = 1'b0;
    sig = '0; trig_level = 16'h8000; rd_addr = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_cv", cv, 0);
    check("rst_trg", trg, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_hold_busy", busy, 0);
    hold = 1'b0;
    @(negedge clk);
    check("prefill_busy", busy, 1);

    // Ramp: dut triggers at store 664 (start_ptr 600), dut4 at its store 166
    sample_en = 1'b1;
    sig = 16'h7D68;
    for (int i = 0; i < 4000 && !(cv && cv4); i++) begin
      @(negedge clk);
      sig = sig + 16'd1;
    end
    sample_en = 1'b0;
    check("ramp_cv", cv, 1);
    check("ramp_trg", trg, 1);
    check("ramp_busy", busy, 0);
    check("ramp4_cv", cv4, 1);
    check("ramp4_trg", trg4, 1);
    check("ramp4_busy", busy4, 0);
    rd("ramp_rd64", 1'b0, 10'd64, 16'h8000);
    rd("ramp_rd0", 1'b0, 10'd0, 16'h7FC0);
    rd("ramp_rd639_wrap", 1'b0, 10'd639, 16'h823F);
    rd("ramp_rd700", 1'b0, 10'd700, 16'h0000);
    rd("ramp4_rd64", 1'b1, 10'd64, 16'h8000);
    rd("ramp4_rd65", 1'b1, 10'd65, 16'h8004);
    rd("ramp4_rd63", 1'b1, 10'd63, 16'h7FFC);
    rd("ramp4_rd0", 1'b1, 10'd0, 16'h7F00);

    // Re-arm blocked by hold
    hold = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    check("hold_cv", cv, 1);
    rd("hold_rd64", 1'b0, 10'd64, 16'h8000);

    // Re-arm, constant below level -> auto trigger after 64+4096+575 stores
    hold = 1'b0; sig = 16'h1000; sample_en = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("rearm_cv_low", cv, 0);
    repeat (4735) @(negedge clk);
    check("auto_not_early", cv, 0);
    @(negedge clk);
    check("auto_cv", cv, 1);
    check("auto_trg", trg, 0);
    sample_en = 1'b0;
    rd("auto_rd0", 1'b0, 10'd0, 16'h1000);
    rd("auto_rd64", 1'b0, 10'd64, 16'h1000);
    rd("auto_rd320", 1'b0, 10'd320, 16'h1000);
    rd("auto_rd639", 1'b0, 10'd639, 16'h1000);

    // Capture into POST, then assert reset mid-cycle
    sig = 16'h0100; sample_en = 1'b1; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (70) @(negedge clk);
    sig = 16'h9000;
    @(negedge clk);
    sig = 16'h0100;
    repeat (10) @(negedge clk);
    check("post_busy", busy, 1);
    check("post_trg", trg, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_cv", cv, 0);
    check("async_rst_trg", trg, 0);
    check("async_rst_rd_data", rd_data, 0);
    sample_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Store k carries value k; crossing at store 11 (PREFILL) must be ignored,
    // crossing at store 100 is the trigger.
    for (int k = 1; k <= 675; k++) begin
      if (k == 11) sig = 16'h900B;
      else if (k == 100) sig = 16'h9064;
      else sig = 16'(k);
      sample_en = 1'b1;
      if (k == 675) check("rst_not_early", cv, 0);
      @(negedge clk);
    end
    sample_en = 1'b0;
    check("rst_cap_cv", cv, 1);
    check("rst_cap_trg", trg, 1);
    rd("rst_rd64", 1'b0, 10'd64, 16'h9064);
    rd("rst_rd63", 1'b0, 10'd63, 16'h0063);
    rd("rst_rd0", 1'b0, 10'd0, 16'h0024);
    rd("rst_rd639", 1'b0, 10'd639, 16'h02A3);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: got %0d pending reads, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
